// File: rtl/regfile_pkg.sv
// Shared register-file types and constants.
// Imported by regfile_wr_decoder and regfile_2r1w.
package regfile_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_wr_decoder.sv
// One-hot write-enable decoder for the register file.
// Bit 0 is never enabled so the zero register stays constant.
module regfile_wr_decoder
   import regfile_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int NREGS  = 2 ** ADDR_W
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              en,
   output logic [NREGS-1:0]  we
);

   always_comb begin
      we = '0;
      if (en) we[addr] = 1'b1;
      we[0] = 1'b0;
   end

endmodule

// File: rtl/regfile_2r1w.sv
// 32x32 register file, two combinational reads, one write, r0 = 0.
// Define WRITE_BYPASS_EN to forward same-cycle write data to readers.
module regfile_2r1w
   import regfile_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] read_addr1,
   input  logic [ADDR_W-1:0] read_addr2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic              reg_write,
   output logic [CNT_W-1:0]  write_count
);

   localparam int NREGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] mem [NREGS];
   logic [NREGS-1:0]  we;
   logic              commit;

   assign commit = reg_write && (write_addr != ZADDR);

   regfile_wr_decoder #(
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
   ) u_dec (
      .addr (write_addr),
      .en   (reg_write),
      .we   (we)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
         write_count <= '0;
      end else begin
         for (int i = 1; i < NREGS; i++)
            if (we[i]) mem[i] <= write_data;
         if (commit && (write_count != '1))
            write_count <= write_count + CNT_W'(1);
      end
   end

   always_comb begin
      read_data1 = (read_addr1 == ZADDR) ? '0 : mem[read_addr1];
      read_data2 = (read_addr2 == ZADDR) ? '0 : mem[read_addr2];
`ifdef WRITE_BYPASS_EN
      // commit already excludes r0, so r0 keeps reading zero
      if (!reset && commit && (read_addr1 == write_addr))
         read_data1 = write_data;
      if (!reset && commit && (read_addr2 == write_addr))
         read_data2 = write_data;
`endif
   end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w.
// Honours WRITE_BYPASS_EN to pick the expected same-cycle read value.
module tb_regfile_2r1w;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  read_addr1, read_addr2, write_addr;
   logic [31:0] read_data1, read_data2, write_data;
   logic        reg_write;
   logic [15:0] write_count;
   logic [31:0] s_rd1, s_rd2;
   logic [3:0]  s_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_2r1w dut (
      .clk         (clk),
      .reset       (reset),
      .read_addr1  (read_addr1),
      .read_addr2  (read_addr2),
      .read_data1  (read_data1),
      .read_data2  (read_data2),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .reg_write   (reg_write),
      .write_count (write_count)
   );

   regfile_2r1w #(.CNT_W(4)) dut_s (
      .clk         (clk),
      .reset       (reset),
      .read_addr1  (read_addr1),
      .read_addr2  (read_addr2),
      .read_data1  (s_rd1),
      .read_data2  (s_rd2),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .reg_write   (reg_write),
      .write_count (s_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && $isunknown(reg_write)) begin
         total++;
         bad++;
         $error("FAIL reg_write_x observed=%b expected=0/1", reg_write);
      end
   end

   initial begin
      logic [31:0] exp7;
      reset = 1'b1; reg_write = 1'b0;
      read_addr1 = '0; read_addr2 = '0;
      write_addr = '0; write_data = '0;
      tick(); tick();
      reset = 1'b0;

      // 1: all zero after reset
      for (int i = 0; i < 32; i++) begin
         read_addr1 = 5'(i);
         read_addr2 = 5'(31 - i);
         #1;
         chk($sformatf("rst_rd1_a%0d", i), read_data1, 32'h0);
         chk($sformatf("rst_rd2_a%0d", 31 - i), read_data2, 32'h0);
      end
      chk("rst_cnt", 32'(write_count), 32'd0);
      chk("rst_cnt_s", 32'(s_cnt), 32'd0);

      // 2: write r5, read on both ports
      write_addr = 5'd5; write_data = 32'hDEADBEEF; reg_write = 1'b1;
      tick();
      reg_write = 1'b0; read_addr1 = 5'd5; read_addr2 = 5'd5;
      #1;
      chk("r5_rd1", read_data1, 32'hDEADBEEF);
      chk("r5_rd2", read_data2, 32'hDEADBEEF);
      chk("r5_cnt", 32'(write_count), 32'd1);

      // 3: write r0 ignored, also no forward on r0
      write_addr = 5'd0; write_data = 32'hFFFFFFFF; reg_write = 1'b1;
      read_addr1 = 5'd0; read_addr2 = 5'd0;
      #1;
      chk("r0_fwd_rd1", read_data1, 32'h0);
      tick();
      reg_write = 1'b0;
      #1;
      chk("r0_rd1", read_data1, 32'h0);
      chk("r0_rd2", read_data2, 32'h0);
      chk("r0_cnt", 32'(write_count), 32'd1);

      // 4: same-cycle read of in-flight r7
      write_addr = 5'd7; write_data = 32'h11111111; reg_write = 1'b1;
      tick();
      write_data = 32'h12345678;
      read_addr1 = 5'd7; read_addr2 = 5'd5;
      #1;
`ifdef WRITE_BYPASS_EN
      exp7 = 32'h12345678;
`else
      exp7 = 32'h11111111;
`endif
      chk("r7_same_cycle", read_data1, exp7);
      chk("r5_other_port", read_data2, 32'hDEADBEEF);
      tick();
      reg_write = 1'b0;
      #1;
      chk("r7_next_cycle", read_data1, 32'h12345678);
      chk("r7_cnt", 32'(write_count), 32'd3);

      // 5: reset beats a simultaneous write
      write_addr = 5'd3; write_data = 32'hA5A5A5A5; reg_write = 1'b1;
      tick();
      reg_write = 1'b0; read_addr1 = 5'd3;
      #1;
      chk("r3_pre", read_data1, 32'hA5A5A5A5);
      chk("r3_pre_cnt", 32'(write_count), 32'd4);
      reset = 1'b1; reg_write = 1'b1; write_data = 32'h1;
      #1;
      chk("r3_rst_nofwd", read_data1, 32'hA5A5A5A5);
      tick();
      reset = 1'b0; reg_write = 1'b0;
      #1;
      chk("r3_post_rst", read_data1, 32'h0);
      chk("r5_post_rst", read_data2, 32'h0);
      chk("cnt_post_rst", 32'(write_count), 32'd0);
      chk("cnt_s_post_rst", 32'(s_cnt), 32'd0);

      // 6: saturation on CNT_W=4 instance, 2**4+3 commits to r1
      write_addr = 5'd1; read_addr1 = 5'd1;
      for (int i = 1; i <= 19; i++) begin
         write_data = 32'(i) * 32'h01010101;
         reg_write = 1'b1;
         tick();
         chk($sformatf("sat_cnt_s_%0d", i), 32'(s_cnt),
             (i > 15) ? 32'd15 : 32'(i));
      end
      reg_write = 1'b0;
      #1;
      chk("sat_cnt_wide", 32'(write_count), 32'd19);
      chk("sat_r1_s", s_rd1, 32'h13131313);
      chk("sat_r1", read_data1, 32'h13131313);
      tick();
      chk("sat_hold", 32'(s_cnt), 32'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
